reg_dump_seq: RTL and testbench

REG_DUMP_SEQ -- requirements
Module: reg_dump_seq

---
 rtl/reg_dump_pkg.sv | 27 ++
 rtl/reg_dump_seq_if.sv | 35 +++
 rtl/reg_dump_seq_lat_counter.sv | 37 +++
 rtl/reg_dump_seq.sv | 149 ++++++++++++++
 tb/tb_reg_dump_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-dump sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package reg_dump_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int INST_W    = 32;

    localparam logic [5:0]           DEFAULT_DUMP_OPCODE = 6'b001000;
    localparam logic [REG_IDX_W-1:0] LAST_IDX            = REG_IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    // Forced read: opcode, rs = idx, rt = r0, zero immediate.
    function automatic logic [INST_W-1:0] dump_inst(input logic [5:0]           opcode,
                                                    input logic [REG_IDX_W-1:0] idx);
        return {opcode, idx, 5'b0_0000, 16'h0000};
    endfunction

endpackage

// File: rtl/reg_dump_seq_if.sv
// Pipeline-probe and dump-record signals between the sequencer and its surroundings.
// Latency: none (wiring only).
// Backpressure: dump_ready stalls the record output.
interface reg_dump_seq_if;
    import reg_dump_pkg::*;

    logic [INST_W-1:0]    busA_probe;
    logic                 override_inst;
    logic [INST_W-1:0]    force_inst;
    logic                 dump_valid;
    logic                 dump_ready;
    logic [REG_IDX_W-1:0] dump_reg;
    logic [INST_W-1:0]    dump_val;

    modport master (
        input  busA_probe,
        input  dump_ready,
        output override_inst,
        output force_inst,
        output dump_valid,
        output dump_reg,
        output dump_val
    );

    modport slave (
        output busA_probe,
        output dump_ready,
        input  override_inst,
        input  force_inst,
        input  dump_valid,
        input  dump_reg,
        input  dump_val
    );

endinterface

// File: rtl/reg_dump_seq_lat_counter.sv
// Loadable 4-bit down-counter timing the wait for the register-file probe.
// Latency: load/decrement visible one cycle later; saturates at zero.
// Backpressure: none.
module lat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero,
    output logic       last
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);
    assign last = (cnt_q == 4'd1);

endmodule

// File: rtl/reg_dump_seq.sv
// Forces register reads into a pipeline and streams all 32 values out (checksum: REG_DUMP_CHECKSUM_EN).
// Latency: first record valid 1+PROBE_LAT cycles after start is sampled.
// Backpressure: record held stable while dump_ready is low; dump paused.
module reg_dump_seq
    import reg_dump_pkg::*;
#(
    parameter int unsigned PROBE_LAT   = 2,
    parameter logic [5:0]  DUMP_OPCODE = DEFAULT_DUMP_OPCODE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    reg_dump_seq_if.master    dif,
    output logic              busy,
    output logic              done,
    output logic [INST_W-1:0] dump_sum
);

    state_t               state_q, state_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;
    logic [INST_W-1:0]    force_inst_q, force_inst_d;
    logic [REG_IDX_W-1:0] dump_reg_q, dump_reg_d;
    logic [INST_W-1:0]    dump_val_q, dump_val_d;
    logic                 override_q, override_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic cnt_load;
    logic cnt_zero;
    logic cnt_last;
    logic wait_exit;

    lat_counter u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (4'(PROBE_LAT)),
        .dec      (state_q == S_WAIT),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // Leave WAIT on the edge where the counter hits zero; the zero term only guards a stuck count.
    assign wait_exit = (state_q == S_WAIT) && (cnt_last || cnt_zero);
    assign cnt_load  = (state_q == S_ISSUE);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        force_inst_d = force_inst_q;
        dump_reg_d   = dump_reg_q;
        dump_val_d   = dump_val_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                end
            end
            S_ISSUE: begin
                force_inst_d = dump_inst(DUMP_OPCODE, idx_q);
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (wait_exit) begin
                    dump_val_d = dif.busA_probe;
                    dump_reg_d = idx_q;
                    state_d    = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (dif.dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        override_d = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_PRESENT);
        valid_d    = (state_d == S_PRESENT);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            force_inst_q <= '0;
            dump_reg_q   <= '0;
            dump_val_q   <= '0;
            override_q   <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            force_inst_q <= force_inst_d;
            dump_reg_q   <= dump_reg_d;
            dump_val_q   <= dump_val_d;
            override_q   <= override_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [INST_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if ((state_q == S_IDLE) && start) begin
            sum_d = '0;
        end else if (wait_exit) begin
            sum_d = sum_q ^ dif.busA_probe;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign dump_sum = sum_q;
`else
    assign dump_sum = '0;
`endif

    assign dif.override_inst = override_q;
    assign dif.force_inst    = force_inst_q;
    assign dif.dump_valid    = valid_q;
    assign dif.dump_reg      = dump_reg_q;
    assign dif.dump_val      = dump_val_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_reg_dump_seq.sv
// Randomized bench for reg_dump_seq: a modelled register file answers the forced reads,
// and every dump is checked against "32 records, indices 0..31, values from the file".
module tb_reg_dump_seq;

    localparam int PL = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] dump_sum;

    reg_dump_seq_if dif ();

    reg_dump_seq #(.PROBE_LAT(PL)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dif      (dif),
        .busy     (busy),
        .done     (done),
        .dump_sum (dump_sum)
    );

    always #5 clk = ~clk;

    logic [31:0] rf [32];
    logic [31:0] noise = 32'hDEAD_BEEF;

    // Pipeline model: port A returns the file entry named by the forced rs field, junk otherwise.
    assign dif.busA_probe = dif.override_inst ? rf[dif.force_inst[25:21]] : noise;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sum_expect(input int last);
        logic [31:0] s;
        s = 32'h0;
`ifdef REG_DUMP_CHECKSUM_EN
        for (int i = 0; i <= last; i++) s ^= rf[i];
`else
        s = 32'h0 & 32'(last);
`endif
        return s;
    endfunction

    // Monitor-owned bookkeeping
    bit mon_en   = 1'b0;
    int exp_next = 0;
    int rec_cnt  = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int last_hs  = 0;
    bit prev_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en && reset) begin
            check("ovr", 32'(dif.override_inst), 32'(busy && !done));
            if (prev_done) check("done_pulse", 32'(done), 32'd0);
            if (dif.dump_valid) check("sum_run", dump_sum, sum_expect(int'(dif.dump_reg)));
            if (dif.dump_valid && dif.dump_ready) begin
                if (exp_next > 31) begin
                    check("extra_rec", 32'd1, 32'd0);
                end else begin
                    check("rec_reg", 32'(dif.dump_reg), 32'(exp_next));
                    check("rec_val", dif.dump_val, rf[exp_next]);
                    check("rec_inst", dif.force_inst, {6'b001000, 5'(exp_next), 21'h0});
                end
                exp_next++;
                rec_cnt++;
                last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                check("done_gap", 32'(cyc - last_hs), 32'd1);
                check("done_all", 32'(exp_next), 32'd32);
                check("sum_done", dump_sum, sum_expect(31));
            end
        end
        prev_done = done;
        if (!busy) exp_next = 0;
    end

    task automatic tick();
        @(posedge clk);
        #2;
        noise = $urandom();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_ovr"},   32'(dif.override_inst), 32'd0);
        check({pfx, "_inst"},  dif.force_inst,         32'd0);
        check({pfx, "_vld"},   32'(dif.dump_valid),    32'd0);
        check({pfx, "_reg"},   32'(dif.dump_reg),      32'd0);
        check({pfx, "_val"},   dif.dump_val,           32'd0);
        check({pfx, "_busy"},  32'(busy),              32'd0);
        check({pfx, "_done"},  32'(done),              32'd0);
        check({pfx, "_sum"},   dump_sum,               32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) rf[i] = $urandom();
    endtask

    task automatic stall_check(input int r);
        dif.dump_ready = 1'b0;
        repeat (10) begin
            tick();
            check("stall_vld", 32'(dif.dump_valid), 32'd1);
            check("stall_reg", 32'(dif.dump_reg),   32'(r));
        end
        check("stall_val",  dif.dump_val,   rf[r]);
        check("stall_inst", dif.force_inst, {6'b001000, 5'(r), 21'h0});
    endtask

    task automatic run_dump(input bit rand_rdy, input int stall_idx, input int restart_idx);
        bit stalled   = 1'b0;
        bit restarted = 1'b0;
        bit seen5     = 1'b0;
        int lat       = 0;
        int base_done = done_cnt;
        int base_rec  = rec_cnt;
        mon_en = 1'b1;
        dif.dump_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (dif.dump_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", 32'(lat), 32'(1 + PL));
        for (int c = 0; c < 4000 && done_cnt == base_done; c++) begin
            if (dif.dump_valid && dif.dump_reg == 5'd5 && !seen5) begin
                seen5 = 1'b1;
                check("inst_idx5", dif.force_inst, 32'h20A0_0000);
            end
            if (dif.dump_valid && int'(dif.dump_reg) == stall_idx && !stalled) begin
                stalled = 1'b1;
                stall_check(stall_idx);
            end
            dif.dump_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (dif.dump_valid && int'(dif.dump_reg) == restart_idx && !restarted) begin
                restarted = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        dif.dump_ready = 1'b1;
        repeat (6) tick();
        check("done_count", 32'(done_cnt - base_done), 32'd1);
        check("rec_count",  32'(rec_cnt - base_rec),   32'd32);
        check("idle_busy",  32'(busy),                 32'd0);
        check("sum_hold",   dump_sum,                  sum_expect(31));
    endtask

    task automatic abort_test();
        bit found = 1'b0;
        fill_random();
        mon_en = 1'b1;
        dif.dump_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (dif.dump_valid && dif.dump_reg == 5'd19) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("abort_reach", 32'(found), 32'd1);
        tick();   // handshake of record 19 -> ISSUE
        tick();   // ISSUE -> WAIT for index 20
        check("abort_in_wait", 32'(dif.override_inst && !dif.dump_valid), 32'd1);
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) tick();
        check("abort_hold_vld", 32'(dif.dump_valid), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        fill_random();
        run_dump(1'b1, -1, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) tick();
        reset = 1'b1;
        tick();

        run_dump(1'b0, -1, -1);

        fill_random();
        run_dump(1'b1, 7, -1);

        fill_random();
        run_dump(1'b1, -1, 12);

        abort_test();

        fill_random();
        run_dump(1'b1, 7, 12);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
